// File: rtl/dmem_port_arbiter_if.sv
// -----------------------------------------------------------------------------
// dmem_port_arbiter_if
// Bundles the requester and memory-side signals of the data-memory port
// arbiter into one interface.
//
//   Core requester : cpu_req, cpu_we, cpu_addr, cpu_wdata  (to arbiter)
//                    cpu_gnt, cpu_rdata, cpu_rvalid        (from arbiter)
//   Host requester : host_req, host_we, host_lock, host_addr, host_wdata
//                    host_gnt, host_rdata, host_rvalid
//   Memory side    : mem_addr, mem_rd, mem_wr, mem_din     (from arbiter)
//                    mem_dout                              (to arbiter)
//   Statistics     : conflict_ct                           (from arbiter)
//
// Modports:
//   master - the environment around the arbiter (requesters plus data_mem)
//   slave  - the arbiter itself
// -----------------------------------------------------------------------------
interface dmem_port_arbiter_if #(
    parameter int AW = 8,
    parameter int DW = 8,
    parameter int CW = 16
);
    logic          cpu_req;
    logic          cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic          cpu_gnt;
    logic [DW-1:0] cpu_rdata;
    logic          cpu_rvalid;

    logic          host_req;
    logic          host_we;
    logic          host_lock;
    logic [AW-1:0] host_addr;
    logic [DW-1:0] host_wdata;
    logic          host_gnt;
    logic [DW-1:0] host_rdata;
    logic          host_rvalid;

    logic [AW-1:0] mem_addr;
    logic          mem_rd;
    logic          mem_wr;
    logic [DW-1:0] mem_din;
    logic [DW-1:0] mem_dout;

    logic [CW-1:0] conflict_ct;

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_gnt, cpu_rdata, cpu_rvalid,
        output host_req, host_we, host_lock, host_addr, host_wdata,
        input  host_gnt, host_rdata, host_rvalid,
        input  mem_addr, mem_rd, mem_wr, mem_din,
        output mem_dout,
        input  conflict_ct
    );

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_gnt, cpu_rdata, cpu_rvalid,
        input  host_req, host_we, host_lock, host_addr, host_wdata,
        output host_gnt, host_rdata, host_rvalid,
        output mem_addr, mem_rd, mem_wr, mem_din,
        input  mem_dout,
        output conflict_ct
    );
endinterface

// File: rtl/dmem_port_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_port_arbiter
// Shares the single-port data_mem between the core (load/store) and a host
// loader/debug port. Grants are combinational and the access happens in the
// grant cycle; read data comes back registered one cycle later.
//
// Arbitration priority (highest first):
//   1) host holds a lock and is within its burst and the core's wait budget
//   2) core has waited STARVE_LIM cycles -> forced core grant
//   3) a single requester -> that requester
//   4) both requesting -> whoever did not own the port last (core wins first)
//
// Ports:
//   CLK      in   clock, rising edge
//   start_n  in   asynchronous reset, active-low
//   bus      slave modport of dmem_port_arbiter_if:
//            core/host request, grant and read-return signals,
//            data_mem address/strobe/data signals, conflict_ct statistic
//
// Parameters:
//   AW, DW      address / data width
//   MAX_BURST   max consecutive host grants under lock (>=1)
//   STARVE_LIM  core wait cycles before a forced core grant (>=1)
//   CW          width of the saturating conflict counter
// -----------------------------------------------------------------------------
module dmem_port_arbiter #(
    parameter int AW         = 8,
    parameter int DW         = 8,
    parameter int MAX_BURST  = 16,
    parameter int STARVE_LIM = 4,
    parameter int CW         = 16
) (
    input  logic               CLK,
    input  logic               start_n,
    dmem_port_arbiter_if.slave bus
);

    localparam int BW = $clog2(MAX_BURST + 1);
    localparam int SW = $clog2(STARVE_LIM + 1);

    localparam logic OWNER_CORE = 1'b0;
    localparam logic OWNER_HOST = 1'b1;

    localparam logic [BW-1:0] BURST_MAX  = BW'(MAX_BURST);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIM);

    // Saturating increments for the three counters.
    function automatic logic [BW-1:0] burst_inc(input logic [BW-1:0] v);
        return (v >= BURST_MAX) ? BURST_MAX : v + BW'(1);
    endfunction

    function automatic logic [SW-1:0] starve_inc(input logic [SW-1:0] v);
        return (v >= STARVE_MAX) ? STARVE_MAX : v + SW'(1);
    endfunction

    function automatic logic [CW-1:0] conflict_inc(input logic [CW-1:0] v);
        return (&v) ? v : v + CW'(1);
    endfunction

    // Registered state
    logic          last_owner;
    logic          lock_q;
    logic [BW-1:0] burst_cnt;
    logic [SW-1:0] starve_cnt;
    logic [CW-1:0] conflict_q;
    logic [DW-1:0] cpu_rdata_q;
    logic [DW-1:0] host_rdata_q;
    logic          cpu_rvalid_q;
    logic          host_rvalid_q;

    // Combinational arbitration
    logic          lock_ok;
    logic          lock_hold;
    logic          starved;
    logic          cpu_gnt;
    logic          host_gnt;

    // Next-state values
    logic          lock_d;
    logic [BW-1:0] burst_d;
    logic [SW-1:0] starve_d;
    logic [CW-1:0] conflict_d;

    // Memory-side mux
    logic [AW-1:0] addr_sel;
    logic [DW-1:0] din_sel;
    logic          rd_sel;
    logic          wr_sel;

    always_comb begin
        lock_ok   = (burst_cnt < BURST_MAX) && (starve_cnt < STARVE_MAX);
        lock_hold = lock_q && bus.host_req && lock_ok;
        starved   = (starve_cnt == STARVE_MAX) && bus.cpu_req;

        cpu_gnt  = 1'b0;
        host_gnt = 1'b0;
        // Grants are suppressed while reset is asserted so no access can
        // reach data_mem during reset.
        if (start_n) begin
            if (lock_hold) begin
                host_gnt = 1'b1;
            end else if (starved) begin
                cpu_gnt = 1'b1;
            end else if (bus.cpu_req && !bus.host_req) begin
                cpu_gnt = 1'b1;
            end else if (bus.host_req && !bus.cpu_req) begin
                host_gnt = 1'b1;
            end else if (bus.cpu_req && bus.host_req) begin
                if (last_owner == OWNER_HOST) begin
                    cpu_gnt = 1'b1;
                end else begin
                    host_gnt = 1'b1;
                end
            end
        end
    end

    always_comb begin
        addr_sel = '0;
        din_sel  = '0;
        rd_sel   = 1'b0;
        wr_sel   = 1'b0;
        if (cpu_gnt) begin
            addr_sel = bus.cpu_addr;
            din_sel  = bus.cpu_wdata;
            rd_sel   = !bus.cpu_we;
            wr_sel   = bus.cpu_we;
        end else if (host_gnt) begin
            addr_sel = bus.host_addr;
            din_sel  = bus.host_wdata;
            rd_sel   = !bus.host_we;
            wr_sel   = bus.host_we;
        end
    end

    always_comb begin
        // The lock is dropped when the host stops requesting, or when the
        // burst/starvation limits block it; a fresh host grant then decides
        // from host_lock whether to (re)take it.
        lock_d = lock_q;
        if (!bus.host_req) begin
            lock_d = 1'b0;
        end else if (lock_q && !lock_ok) begin
            lock_d = 1'b0;
        end else if (host_gnt) begin
            lock_d = bus.host_lock;
        end

        burst_d = burst_cnt;
        if (!lock_d || cpu_gnt) begin
            burst_d = '0;
        end else if (host_gnt) begin
            burst_d = burst_inc(burst_cnt);
        end

        starve_d = starve_cnt;
        if (!bus.cpu_req || cpu_gnt) begin
            starve_d = '0;
        end else begin
            starve_d = starve_inc(starve_cnt);
        end

        conflict_d = conflict_q;
        if (bus.cpu_req && bus.host_req) begin
            conflict_d = conflict_inc(conflict_q);
        end
    end

    always_ff @(posedge CLK or negedge start_n) begin
        if (!start_n) begin
            last_owner <= OWNER_HOST;
            lock_q     <= 1'b0;
            burst_cnt  <= '0;
            starve_cnt <= '0;
            conflict_q <= '0;
        end else begin
            if (cpu_gnt) begin
                last_owner <= OWNER_CORE;
            end else if (host_gnt) begin
                last_owner <= OWNER_HOST;
            end
            lock_q     <= lock_d;
            burst_cnt  <= burst_d;
            starve_cnt <= starve_d;
            conflict_q <= conflict_d;
        end
    end

    // Read return: data_mem reads combinationally, so the word is captured
    // at the end of the grant cycle and flagged valid for exactly one cycle.
    always_ff @(posedge CLK or negedge start_n) begin
        if (!start_n) begin
            cpu_rdata_q   <= '0;
            host_rdata_q  <= '0;
            cpu_rvalid_q  <= 1'b0;
            host_rvalid_q <= 1'b0;
        end else begin
            cpu_rvalid_q  <= cpu_gnt && !bus.cpu_we;
            host_rvalid_q <= host_gnt && !bus.host_we;
            if (cpu_gnt && !bus.cpu_we) begin
                cpu_rdata_q <= bus.mem_dout;
            end
            if (host_gnt && !bus.host_we) begin
                host_rdata_q <= bus.mem_dout;
            end
        end
    end

    assign bus.cpu_gnt     = cpu_gnt;
    assign bus.host_gnt    = host_gnt;
    assign bus.cpu_rdata   = cpu_rdata_q;
    assign bus.host_rdata  = host_rdata_q;
    assign bus.cpu_rvalid  = cpu_rvalid_q;
    assign bus.host_rvalid = host_rvalid_q;
    assign bus.mem_addr    = addr_sel;
    assign bus.mem_din     = din_sel;
    assign bus.mem_rd      = rd_sel;
    assign bus.mem_wr      = wr_sel;
    assign bus.conflict_ct = conflict_q;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dmem_port_arbiter
// Directed bench for dmem_port_arbiter. The stimulus process drives one cycle
// at a time and queues the hand-computed expected response for that cycle;
// a monitor on the falling edge pops each entry and compares it with the DUT.
// A small behavioural data_mem sits on the memory side.
// -----------------------------------------------------------------------------
module tb_dmem_port_arbiter;

    localparam int AW = 8;
    localparam int DW = 8;
    localparam int CW = 16;

    localparam int N = 0;  // no grant expected
    localparam int C = 1;  // core grant expected
    localparam int H = 2;  // host grant expected

    logic CLK = 1'b0;
    logic start_n;

    always #5 CLK = ~CLK;

    dmem_port_arbiter_if #(.AW(AW), .DW(DW), .CW(CW)) bus ();

    dmem_port_arbiter #(
        .AW(AW), .DW(DW), .MAX_BURST(16), .STARVE_LIM(4), .CW(CW)
    ) dut (
        .CLK    (CLK),
        .start_n(start_n),
        .bus    (bus)
    );

    // Behavioural data_mem: combinational read, write at the clock edge.
    logic [DW-1:0] mem [0:255];
    assign bus.mem_dout = mem[bus.mem_addr];
    always @(posedge CLK) begin
        if (bus.mem_wr) mem[bus.mem_addr] <= bus.mem_din;
    end

    typedef struct {
        int            who;
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] din;
        logic          crv;
        logic [DW-1:0] crd;
        logic          hrv;
        logic [DW-1:0] hrd;
        int            cct;   // -1: not checked this cycle
        logic          rst;
    } exp_t;

    exp_t gq[$];
    exp_t e;
    int   n_vec = 0;
    int   n_err = 0;
    int   cyc   = 0;
    logic done  = 1'b0;

    logic          prev_crv = 1'b0;
    logic [DW-1:0] prev_crd = '0;
    logic          prev_hrv = 1'b0;
    logic [DW-1:0] prev_hrd = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Queue the expectation for the cycle whose inputs were just driven,
    // then advance to just after the next rising edge.
    task automatic step(input int who, input logic [DW-1:0] rd, input int cct);
        exp_t x;
        logic in_rst;
        in_rst = !start_n;
        x.who  = who;
        x.we   = (who == C) ? bus.cpu_we    : bus.host_we;
        x.addr = (who == C) ? bus.cpu_addr  : bus.host_addr;
        x.din  = (who == C) ? bus.cpu_wdata : bus.host_wdata;
        x.crv  = prev_crv && !in_rst;
        x.crd  = prev_crd;
        x.hrv  = prev_hrv && !in_rst;
        x.hrd  = prev_hrd;
        x.cct  = cct;
        x.rst  = in_rst;
        prev_crv = !in_rst && (who == C) && !bus.cpu_we;
        prev_crd = rd;
        prev_hrv = !in_rst && (who == H) && !bus.host_we;
        prev_hrd = rd;
        gq.push_back(x);
        @(posedge CLK);
        #1;
    endtask

    task automatic idle();
        bus.cpu_req   = 1'b0;
        bus.host_req  = 1'b0;
        bus.host_lock = 1'b0;
    endtask

    // Monitor
    always @(negedge CLK) begin
        cyc++;
        if (gq.size() != 0) begin
            e = gq.pop_front();
            check("grant", {30'd0, bus.cpu_gnt, bus.host_gnt},
                  {30'd0, (e.who == C), (e.who == H)});
            if (e.who != N) begin
                check("mem_bus", {14'd0, bus.mem_wr, bus.mem_rd, bus.mem_addr, bus.mem_din},
                      {14'd0, e.we, !e.we, e.addr, e.din});
            end else begin
                check("idle_mem", {14'd0, bus.mem_wr, bus.mem_rd, bus.mem_addr, bus.mem_din},
                      32'd0);
            end
            check("cpu_rvalid", {31'd0, bus.cpu_rvalid}, {31'd0, e.crv});
            if (e.crv) check("cpu_rdata", {24'd0, bus.cpu_rdata}, {24'd0, e.crd});
            check("host_rvalid", {31'd0, bus.host_rvalid}, {31'd0, e.hrv});
            if (e.hrv) check("host_rdata", {24'd0, bus.host_rdata}, {24'd0, e.hrd});
            if (e.cct >= 0) check("conflict_ct", {16'd0, bus.conflict_ct}, e.cct);
            if (e.rst) check("reset_rdata", {16'd0, bus.cpu_rdata, bus.host_rdata}, 32'd0);
        end else if (done) begin
            $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
            $finish;
        end else if (cyc > 3000) begin
            n_vec++;
            n_err++;
            $display("FAIL timeout: stimulus stalled at cycle %0d, want completion", cyc);
            $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
            $finish;
        end
    end

    // Stimulus
    initial begin
        bus.cpu_req    = 1'b0;
        bus.cpu_we     = 1'b0;
        bus.cpu_addr   = '0;
        bus.cpu_wdata  = '0;
        bus.host_req   = 1'b0;
        bus.host_we    = 1'b0;
        bus.host_lock  = 1'b0;
        bus.host_addr  = '0;
        bus.host_wdata = '0;
        start_n = 1'b1;
        #2 start_n = 1'b0;
        @(posedge CLK);
        #1;

        // Reset with both requesters active: nothing may reach the memory.
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 8'h05; bus.cpu_wdata = 8'hEE;
        bus.host_req = 1'b1; bus.host_we = 1'b1; bus.host_lock = 1'b1;
        bus.host_addr = 8'h06; bus.host_wdata = 8'hDD;
        step(N, '0, 0);
        start_n = 1'b1;
        idle();
        step(N, '0, 0);

        // Tie for 6 cycles: core first, then alternating.
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 8'h10; bus.cpu_wdata = 8'h11;
        bus.host_req = 1'b1; bus.host_we = 1'b1; bus.host_lock = 1'b0;
        bus.host_addr = 8'h30; bus.host_wdata = 8'h33;
        for (int i = 0; i < 6; i++) step((i % 2 == 0) ? C : H, '0, i);
        idle();
        step(N, '0, 6);

        // Core only: write then read back.
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 8'h20; bus.cpu_wdata = 8'hA5;
        step(C, '0, 6);
        bus.cpu_we = 1'b0; bus.cpu_wdata = 8'h00;
        step(C, 8'hA5, 6);
        idle();
        step(N, '0, 6);

        // Locked host burst of 20 beats, core idle: every beat granted.
        bus.host_req = 1'b1; bus.host_we = 1'b1; bus.host_lock = 1'b1;
        for (int i = 0; i < 20; i++) begin
            bus.host_addr  = 8'(8'h40 + i);
            bus.host_wdata = 8'(8'h80 + i);
            step(H, '0, -1);
        end
        idle();
        step(N, '0, 6);

        // 16 locked beats, then the core asks: lock has expired, core wins.
        bus.host_req = 1'b1; bus.host_we = 1'b1; bus.host_lock = 1'b1;
        for (int i = 0; i < 16; i++) begin
            bus.host_addr  = 8'(8'h60 + i);
            bus.host_wdata = 8'(8'hC0 + i);
            step(H, '0, 6);
        end
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 8'h22; bus.cpu_wdata = 8'h77;
        bus.host_addr = 8'h70; bus.host_wdata = 8'hD0;
        step(C, '0, 6);
        bus.cpu_req = 1'b0;
        step(H, '0, 7);
        idle();
        step(N, '0, 7);

        // Starvation: host locked, core waits 4 cycles then is forced in.
        bus.host_req = 1'b1; bus.host_we = 1'b1; bus.host_lock = 1'b1;
        bus.host_addr = 8'h71; bus.host_wdata = 8'hD1;
        step(H, '0, 7);
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 8'h20; bus.cpu_wdata = 8'h00;
        for (int i = 0; i < 4; i++) begin
            bus.host_addr  = 8'(8'h72 + i);
            bus.host_wdata = 8'(8'hD2 + i);
            step(H, '0, 7 + i);
        end
        step(C, 8'hA5, 11);
        bus.cpu_req = 1'b0;
        step(H, '0, 12);
        idle();
        step(N, '0, 12);

        // Locked host read burst, reset during beat 5.
        bus.host_req = 1'b1; bus.host_we = 1'b0; bus.host_lock = 1'b1;
        for (int i = 0; i < 5; i++) begin
            bus.host_addr = 8'(8'h40 + i);
            step(H, 8'(8'h80 + i), -1);
        end
        bus.host_addr = 8'h45;
        start_n = 1'b0;
        step(N, '0, 0);
        start_n = 1'b1;
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 8'h21; bus.cpu_wdata = 8'h5A;
        step(C, '0, 0);
        bus.cpu_req = 1'b0;
        step(H, 8'h85, 1);
        idle();
        step(N, '0, 1);

        done = 1'b1;
    end

endmodule
